// File: rtl/tour_pkg.sv
// tour_pkg: shared types and constants for the knight's-tour command replayer.
// States, command opcodes, compass headings and UART response bytes live here
// so the top and the bench-facing encodings stay in one place.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VERT   = 3'd1,
      HOLD_V = 3'd2,
      HORZ   = 3'd3,
      HOLD_H = 3'd4
   } tour_state_e;

   // Command opcodes
   localparam logic [3:0] MOVE         = 4'h2;
   localparam logic [3:0] MOVE_FANFARE = 4'h3;

   // Headings
   localparam logic [7:0] NORTH = 8'h00;
   localparam logic [7:0] SOUTH = 8'h7F;
   localparam logic [7:0] WEST  = 8'h3F;
   localparam logic [7:0] EAST  = 8'hBF;

   // Response bytes: idle vs. tour in progress
   localparam logic [7:0] RESP_IDLE = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;

   // Index of the final move of a 5x5 tour (24 moves, 0..23)
   localparam logic [4:0] LAST_MOVE = 5'd23;

   // Magnitude of a signed 3-bit offset as a 4-bit square count
   function automatic logic [3:0] mag3(input logic signed [2:0] v);
      logic [2:0] n;
      n = v[2] ? -v : v;
      return {1'b0, n};
   endfunction

endpackage

// File: rtl/tour_cmd_move_decode.sv
// move_decode: maps a one-hot knight move to signed (dx, dy) square offsets.
// Anything that is not exactly one-hot decodes to no motion.
module move_decode
   import tour_pkg::*;
(
   input  logic        [7:0] move,
   output logic signed [2:0] dx,
   output logic signed [2:0] dy
);

   // One-hot knight move table; default covers zero and multi-hot inputs
   always_comb begin
      dx = 3'sd0;
      dy = 3'sd0;
      case (move)
         8'h01: begin dx = -3'sd1; dy =  3'sd2; end
         8'h02: begin dx =  3'sd1; dy =  3'sd2; end
         8'h04: begin dx = -3'sd2; dy =  3'sd1; end
         8'h08: begin dx = -3'sd2; dy = -3'sd1; end
         8'h10: begin dx = -3'sd1; dy = -3'sd2; end
         8'h20: begin dx =  3'sd1; dy = -3'sd2; end
         8'h40: begin dx =  3'sd2; dy =  3'sd1; end
         8'h80: begin dx =  3'sd2; dy = -3'sd1; end
         default: begin dx = 3'sd0; dy = 3'sd0; end
      endcase
   end

endmodule

// File: rtl/tour_cmd.sv
// tour_cmd: replays a solved knight's tour as pairs of MOVE commands
// (vertical leg, then horizontal leg) and otherwise passes UART commands
// straight through to the command processor.
// Build option: define TOUR_FANFARE_EN to issue the horizontal leg as
// MOVE_FANFARE so each completed knight move plays a tune.
module tour_cmd
   import tour_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] HORZ_OPC = MOVE_FANFARE;
`else
   localparam logic [3:0] HORZ_OPC = MOVE;
`endif

   tour_state_e        state_q, state_d;
   logic [4:0]         mv_indx_q, mv_indx_d;
   logic [7:0]         move_q, move_d;
   logic [7:0]         cur_move;
   logic signed [2:0]  dx, dy;
   logic [15:0]        vert_cmd, horz_cmd;

   // While the vertical leg is offered the live move is used; once it is
   // taken the move is frozen so both legs stay stable even if the solver
   // output wanders.
   assign cur_move = (state_q == VERT) ? move : move_q;

   move_decode u_move_decode (
      .move (cur_move),
      .dx   (dx),
      .dy   (dy)
   );

   assign vert_cmd = {MOVE,     (dy > 3'sd0) ? NORTH : SOUTH, mag3(dy)};
   assign horz_cmd = {HORZ_OPC, dx[2]        ? WEST  : EAST,  mag3(dx)};

   assign mv_indx = mv_indx_q;
   assign resp    = (state_q == IDLE) ? RESP_IDLE : RESP_BUSY;

   // Capture the move being replayed for the remainder of the pair
   always_comb begin
      move_d = cur_move;
   end

   // Next-state and command muxing; UART path only open in IDLE
   always_comb begin
      state_d          = state_q;
      mv_indx_d        = mv_indx_q;
      cmd              = vert_cmd;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      case (state_q)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            if (start_tour) begin
               mv_indx_d = 5'd0;
               state_d   = VERT;
            end
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
            // clr_cmd_rdy wins over a coincident send_resp
            if (clr_cmd_rdy) state_d = HOLD_V;
         end
         HOLD_V: begin
            cmd = vert_cmd;
            if (send_resp) state_d = HORZ;
         end
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy) state_d = HOLD_H;
         end
         HOLD_H: begin
            cmd = horz_cmd;
            if (send_resp) begin
               if (mv_indx_q == LAST_MOVE) begin
                  state_d = IDLE;
               end else begin
                  mv_indx_d = mv_indx_q + 5'd1;
                  state_d   = VERT;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, move index and frozen move registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mv_indx_q <= 5'd0;
         move_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
         move_q    <= move_d;
      end
   end

endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: randomized + directed bench for tour_cmd. The reference model
// tracks tour progress as a single step counter (4 steps per knight move) and
// derives commands from a dx/dy lookup table.
module tb_tour_cmd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_tour = 1'b0;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART = 16'h0000;
   logic        cmd_rdy_UART = 1'b0;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        send_resp = 1'b0;
   logic [7:0]  resp;

   logic [7:0]  tour_mv [0:23];
   int          DXT [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
   int          DYT [8] = '{ 2,  2,  1, -1, -2, -2,  1, -1};

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int m_step = -1;   // -1 idle, else 4*move + {0 vert offer,1 vert hold,2 horz offer,3 horz hold}
   int m_idx  = 0;

`ifdef TOUR_FANFARE_EN
   localparam logic [3:0]  H_OPC = 4'h3;
   localparam logic [15:0] R0_H  = 16'h33F1;
   localparam logic [15:0] R1_H  = 16'h3BF2;
`else
   localparam logic [3:0]  H_OPC = 4'h2;
   localparam logic [15:0] R0_H  = 16'h23F1;
   localparam logic [15:0] R1_H  = 16'h2BF2;
`endif

   always #5 clk = ~clk;

   assign move = (mv_indx < 5'd24) ? tour_mv[mv_indx] : 8'h00;

   tour_cmd dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp)
   );

   function automatic logic [15:0] exp_cmd(input int step, input int idx);
      int dxv, dyv, ax, ay;
      logic [7:0] mv;
      mv  = tour_mv[idx];
      dxv = 0;
      dyv = 0;
      if ($countones(mv) == 1)
         for (int k = 0; k < 8; k++)
            if (mv[k]) begin dxv = DXT[k]; dyv = DYT[k]; end
      ax = (dxv < 0) ? -dxv : dxv;
      ay = (dyv < 0) ? -dyv : dyv;
      if ((step % 4) < 2) return {4'h2, (dyv > 0) ? 8'h00 : 8'h7F, ay[3:0]};
      else                return {H_OPC, (dxv < 0) ? 8'h3F : 8'hBF, ax[3:0]};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tour progress as a step counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_step <= -1;
         m_idx  <= 0;
      end else if (m_step < 0) begin
         if (start_tour) begin m_step <= 0; m_idx <= 0; end
      end else begin
         case (m_step % 4)
            0, 2: if (clr_cmd_rdy) m_step <= m_step + 1;
            1:    if (send_resp)   m_step <= m_step + 1;
            default: if (send_resp) begin
               if (m_idx == 23) m_step <= -1;
               else begin m_step <= m_step + 1; m_idx <= m_idx + 1; end
            end
         endcase
      end
   end

   // Compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         if (m_step < 0) begin
            chk("idle_cmd",     cmd,              cmd_UART);
            chk("idle_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, cmd_rdy_UART});
            chk("idle_clr",     {15'd0, clr_cmd_rdy_UART}, {15'd0, clr_cmd_rdy});
            chk("idle_resp",    {8'd0, resp},     16'h00A5);
         end else begin
            chk("tour_cmd",     cmd,              exp_cmd(m_step, m_idx));
            chk("tour_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, ((m_step % 2) == 0)});
            chk("tour_clr",     {15'd0, clr_cmd_rdy_UART}, 16'd0);
            chk("tour_resp",    {8'd0, resp},     16'h005A);
         end
         chk("mv_indx", {11'd0, mv_indx}, m_idx[15:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_in();
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
   endtask

   // Random handshakes (with stray start_tour pulses) until the model reaches target
   task automatic run_until(input string name, input int target, input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         clr_cmd_rdy = 1'($urandom_range(0, 1));
         send_resp   = 1'($urandom_range(0, 1));
         start_tour  = ($urandom_range(0, 3) == 0);
         tick();
         if (m_step == target) done = 1'b1;
      end
      zero_in();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: timeout waiting for step %0d, model at %0d", name, target, m_step);
      end
   endtask

   initial begin
      for (int i = 0; i < 24; i++) tour_mv[i] = 8'h01 << $urandom_range(0, 7);
      tour_mv[0] = 8'h01;
      tour_mv[1] = 8'h80;
      tour_mv[5] = 8'h00;
      tour_mv[9] = 8'h18;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (2) tick();
      chk("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
      chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("rst_resp",    {8'd0, resp},     16'h00A5);
      rst_n = 1'b1;
      tick();

      // IDLE pass-through
      cmd_UART = 16'h2005; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
      #1;
      chk("pt_cmd",     cmd, 16'h2005);
      chk("pt_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
      chk("pt_clr_hi",  {15'd0, clr_cmd_rdy_UART}, 16'd1);
      chk("pt_resp",    {8'd0, resp}, 16'h00A5);
      clr_cmd_rdy = 1'b0;
      #1;
      chk("pt_clr_lo",  {15'd0, clr_cmd_rdy_UART}, 16'd0);
      tick();

      // Directed replay of moves 0 and 1
      cmd_rdy_UART = 1'b0;
      start_tour = 1'b1; tick(); start_tour = 1'b0;
      chk("r0_vert", cmd, 16'h2002);
      chk("r0_vert_rdy", {15'd0, cmd_rdy}, 16'd1);
      tick();
      clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
      chk("r0_hold_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("r0_hold_cmd", cmd, 16'h2002);
      send_resp = 1'b1; tick(); send_resp = 1'b0;
      chk("r0_horz", cmd, R0_H);
      clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick(); zero_in();
      chk("r0_both_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("r0_both_idx", {11'd0, mv_indx}, 16'd0);
      send_resp = 1'b1; tick(); send_resp = 1'b0;
      chk("r1_vert", cmd, 16'h27F1);
      chk("r1_idx", {11'd0, mv_indx}, 16'd1);
      clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
      send_resp = 1'b1;   tick(); send_resp = 1'b0;
      chk("r1_horz", cmd, R1_H);

      // Finish the tour with random handshakes and stray start pulses
      run_until("full_tour", -1, 3000);
      chk("end_resp", {8'd0, resp}, 16'h00A5);
      chk("end_idx",  {11'd0, mv_indx}, 16'd23);
      tick();

      // Reset mid-tour in HOLD_H of move 10
      start_tour = 1'b1; tick(); start_tour = 1'b0;
      run_until("to_move10", 43, 3000);
      chk("pre_rst_idx", {11'd0, mv_indx}, 16'd10);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_idx",  {11'd0, mv_indx}, 16'd0);
      chk("mid_rst_rdy",  {15'd0, cmd_rdy}, 16'd0);
      chk("mid_rst_resp", {8'd0, resp}, 16'h00A5);
      tick();
      rst_n = 1'b1; cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b1;
      #1;
      chk("post_rst_cmd", cmd, 16'hBEEF);
      chk("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);
      tick();

      // UART command held pending across a full tour
      cmd_UART = 16'h1234;
      start_tour = 1'b1; tick(); start_tour = 1'b0;
      run_until("held_tour", -1, 3000);
      chk("held_fwd_cmd", cmd, 16'h1234);
      chk("held_fwd_rdy", {15'd0, cmd_rdy}, 16'd1);
      tick();

      // Random soak with a fresh tour table
      cmd_rdy_UART = 1'b0;
      for (int i = 0; i < 24; i++)
         tour_mv[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      for (int c = 0; c < 3000; c++) begin
         start_tour   = ($urandom_range(0, 7) == 0);
         clr_cmd_rdy  = 1'($urandom_range(0, 1));
         send_resp    = 1'($urandom_range(0, 1));
         cmd_UART     = 16'($urandom);
         cmd_rdy_UART = 1'($urandom_range(0, 1));
         rst_n        = ($urandom_range(0, 399) != 0);
         tick();
      end
      rst_n = 1'b1;
      zero_in();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
